count_display_driver: RTL and testbench

Downstream consumer of the 4-bit binary counter. It renders the live count on a 4-digit, common-anode, multiplexed seven-segment display:
- digits 1:0 show the count in decimal (00–15);
- digit 3 shows the same value in hex (0–F);
- digit 2 is always blank.

It owns the refresh prescaler, the digit-scan FSM, the per-frame input snapshot and a wrap indicator on the decimal point.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_decoder.sv | 32 +++
 rtl/count_display_driver.sv | 112 +++++++++++
 tb/tb_count_display_driver.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment glyphs (active-low {g,f,e,d,c,b,a}), scan states and anode patterns
// shared by the display driver and its decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_state_t;

  function automatic logic [3:0] anode_of(input scan_state_t s);
    case (s)
      D0:      anode_of = 4'b1110;
      D1:      anode_of = 4'b1101;
      D2:      anode_of = 4'b1011;
      default: anode_of = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to active-low hex glyph; zero latency, no flow control.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (val)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// Multiplexed 4-digit display of a 4-bit count: decimal on digits 1:0, hex on digit 3.
// Outputs registered; a new count is shown within one frame plus one edge; no backpressure.
module count_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  scan_state_t   state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [3:0]    snap, snap_nx;
  logic          wrap, wrap_nx;
  logic          start;
  logic          tick;

  logic          tens_nx;
  logic [3:0]    ones_nx;
  logic [3:0]    dig;
  logic          dig_blank;
  logic [6:0]    dig_seg;

  // start marks the first edge after reset: snapshot taken, prescaler held at 0
  // so the opening D0 dwell is a full REFRESH_DIV cycles.
  assign tick = (pre == PRE_MAX) && !start;

  always_ff @(posedge clk) begin
    if (rst) state <= D0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    snap_nx  = snap;
    wrap_nx  = wrap;
    if (start) begin
      state_nx = D0;
      pre_nx   = '0;
      snap_nx  = count_in;
      wrap_nx  = 1'b0;
    end else begin
      pre_nx = tick ? '0 : pre + 1'b1;
      if (tick) begin
        case (state)
          D0: state_nx = D1;
          D1: state_nx = D2;
          D2: state_nx = D3;
          default: begin
            state_nx = D0;
            snap_nx  = count_in;
            wrap_nx  = (count_in < snap);
          end
        endcase
      end
    end
  end

  // Digit content is derived from next-state values so the registered outputs
  // line up with the state they describe.
  always_comb begin
    tens_nx   = (snap_nx >= 4'd10);
    ones_nx   = tens_nx ? (snap_nx - 4'd10) : snap_nx;
    dig       = 4'd0;
    dig_blank = 1'b0;
    case (state_nx)
      D0: dig = ones_nx;
      D1: begin
        dig       = {3'b000, tens_nx};
        dig_blank = BLANK_LZ && !tens_nx;
      end
      D2: dig_blank = 1'b1;
      default: dig = snap_nx;
    endcase
  end

  seg7_decoder u_dec (
    .val (dig),
    .seg (dig_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      snap  <= 4'd0;
      wrap  <= 1'b0;
      start <= 1'b1;
      an    <= AN_OFF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      pre   <= pre_nx;
      snap  <= snap_nx;
      wrap  <= wrap_nx;
      start <= 1'b0;
      an    <= anode_of(state_nx);
      seg   <= dig_blank ? SEG_BLANK : dig_seg;
      dp    <= !((state_nx == D0) && wrap_nx);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Drives both BLANK_LZ variants at REFRESH_DIV=4 from a row table; expected outputs
// are queued at drive time and checked one edge later.
module tb_count_display_driver;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000, G9 = 7'b0010000, GD = 7'b0100001;
  localparam logic [6:0] GF = 7'b0001110, BL = 7'b1111111;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AX = 4'b1111;

  typedef struct {
    logic       rst;
    logic [3:0] cin;
    int         n;
    logic [3:0] an;
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic       dp;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_lz1 (
    .clk(clk), .rst(rst), .count_in(count_in), .an(an1), .seg(seg1), .dp(dp1)
  );

  count_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_lz0 (
    .clk(clk), .rst(rst), .count_in(count_in), .an(an0), .seg(seg0), .dp(dp0)
  );

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({an1, seg1, dp1} !== {e.an, e.seg1, e.dp}) begin
        n_bad++;
        $display("FAIL lz1 t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 $time, an1, seg1, dp1, e.an, e.seg1, e.dp);
      end
      n_cmp++;
      if ({an0, seg0, dp0} !== {e.an, e.seg0, e.dp}) begin
        n_bad++;
        $display("FAIL lz0 t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 $time, an0, seg0, dp0, e.an, e.seg0, e.dp);
      end
    end
  end

  task automatic row(input logic r, input logic [3:0] c, input int n, input logic [3:0] a,
                     input logic [6:0] s1, input logic [6:0] s0, input logic d);
    vecs.push_back('{rst: r, cin: c, n: n, an: a, seg1: s1, seg0: s0, dp: d});
  endtask

  // One full frame at a steady count_in; first row's first edge is the snapshot edge.
  task automatic frame(input logic [3:0] c, input logic [6:0] ones, input logic [6:0] t1,
                       input logic [6:0] t0, input logic [6:0] hex, input logic dpd0);
    row(1'b0, c, 4, A0, ones, ones, dpd0);
    row(1'b0, c, 4, A1, t1, t0, 1'b1);
    row(1'b0, c, 4, A2, BL, BL, 1'b1);
    row(1'b0, c, 4, A3, hex, hex, 1'b1);
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic [3:0] a,
                      input logic [6:0] s1, input logic [6:0] s0, input logic d);
    @(negedge clk);
    rst      = r;
    count_in = c;
    sb.push_back('{an: a, seg1: s1, seg0: s0, dp: d});
  endtask

  initial begin
    rst      = 1'b1;
    count_in = 4'd9;

    row(1'b1, 4'd9, 3, AX, BL, BL, 1'b1);             // reset held
    frame(4'd9,  G9, BL, G0, G9, 1'b1);               // first frame after release
    frame(4'd13, G3, G1, G1, GD, 1'b1);
    row(1'b0, 4'd3, 4, A0, G3, G3, 1'b0);             // 13 -> 3 wraps
    row(1'b0, 4'd3, 2, A1, BL, G0, 1'b1);
    row(1'b0, 4'd7, 2, A1, BL, G0, 1'b1);             // mid-frame change ignored
    row(1'b0, 4'd7, 4, A2, BL, BL, 1'b1);
    row(1'b0, 4'd7, 4, A3, G3, G3, 1'b1);
    frame(4'd7,  G7, BL, G0, G7, 1'b1);
    frame(4'd15, G5, G1, G1, GF, 1'b1);
    frame(4'd0,  G0, BL, G0, G0, 1'b0);               // 15 -> 0 wrap
    frame(4'd1,  G1, BL, G0, G1, 1'b1);
    frame(4'd5,  G5, BL, G0, G5, 1'b1);
    row(1'b0, 4'd10, 4, A0, G0, G0, 1'b1);            // tens boundary
    row(1'b0, 4'd10, 4, A1, G1, G1, 1'b1);
    row(1'b0, 4'd10, 2, A2, BL, BL, 1'b1);
    row(1'b1, 4'd10, 2, AX, BL, BL, 1'b1);            // reset mid-D2
    row(1'b0, 4'd2, 4, A0, G2, G2, 1'b1);             // 2 < 10 but wrap cleared
    row(1'b0, 4'd2, 4, A1, BL, G0, 1'b1);
    row(1'b0, 4'd2, 4, A2, BL, BL, 1'b1);
    row(1'b0, 4'd2, 4, A3, G2, G2, 1'b1);

    foreach (vecs[i])
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].rst, vecs[i].cin, vecs[i].an, vecs[i].seg1, vecs[i].seg0, vecs[i].dp);

    // rst on the snapshot edge must win over the tick
    step(1'b1, 4'd4, AX, BL, BL, 1'b1);
    step(1'b0, 4'd4, A0, G4, G4, 1'b1);
    step(1'b0, 4'd8, A0, G4, G4, 1'b1);
    step(1'b0, 4'd8, A0, G4, G4, 1'b1);
    step(1'b0, 4'd8, A0, G4, G4, 1'b1);
    step(1'b0, 4'd8, A1, BL, G0, 1'b1);

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
